bram_dut_sequencer: RTL and testbench

//   Drives the cascaded-BRAM power-test array and collects its results. Issues a
//   one-cycle dut_start and a dut_enable window per run, waits for the array to

---
 rtl/bram_dut_sequencer.sv | 148 ++++++++++++++
 tb/tb_bram_dut_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_dut_sequencer.sv
// Purpose: sequences start/enable/settle/check runs on the cascaded-BRAM power-test array and gathers results.
// Latency: every output is a register of the next-state decode; one run spans 1+RUN_CYCLES+SETTLE_CYCLES+1 cycles.
// Backpressure: none; go is accepted only in IDLE, and abort (any non-IDLE state) returns to IDLE on the next edge.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   go             start request, level-sampled in IDLE
//   abort          stop the sequence from any non-IDLE state
//   pass_i         per-instance pass flags, sampled only in CHECK
//   dut_start      one-cycle start pulse to the array
//   dut_enable     activity enable, high for 1+RUN_CYCLES cycles per run
//   busy           high in every state except IDLE
//   done           one-cycle pulse on normal completion
//   all_pass       last completed sequence saw no failures
//   fail_mask      sticky OR of ~pass_i over all CHECK samples
//   run_count      completed runs, saturating
module bram_dut_sequencer #(
  parameter int NUM           = 40,
  parameter int RUN_CYCLES    = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_RUNS      = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic [NUM-1:0]   pass_i,
  output logic             dut_start,
  output logic             dut_enable,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [NUM-1:0]   fail_mask,
  output logic [CNT_W-1:0] run_count
);

  localparam int MAX_CYC = (RUN_CYCLES > SETTLE_CYCLES) ? RUN_CYCLES : SETTLE_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0]    RUN_LOAD    = TW'(RUN_CYCLES - 1);
  localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RUNS_TGT    = CNT_W'(NUM_RUNS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [NUM-1:0]   fail_mask_nxt;
  logic [CNT_W-1:0] run_count_nxt;
  logic             all_pass_nxt;

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    fail_mask_nxt = fail_mask;
    run_count_nxt = run_count;
    all_pass_nxt  = all_pass;

    // abort wins over every other transition; results collected so far are kept
    if (state != S_IDLE && abort) begin
      state_nxt    = S_IDLE;
      all_pass_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            fail_mask_nxt = '0;
            run_count_nxt = '0;
            all_pass_nxt  = 1'b0;
            state_nxt     = S_START;
          end
        end
        S_START: begin
          timer_nxt = RUN_LOAD;
          state_nxt = S_RUN;
        end
        S_RUN: begin
          if (timer == '0) begin
            timer_nxt = SETTLE_LOAD;
            state_nxt = S_SETTLE;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        S_SETTLE: begin
          if (timer == '0) begin
            state_nxt = S_CHECK;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        S_CHECK: begin
          fail_mask_nxt = fail_mask | ~pass_i;
          if (run_count != CNT_MAX) begin
            run_count_nxt = run_count + 1'b1;
          end
          if (NUM_RUNS != 0 && run_count_nxt == RUNS_TGT) begin
            // verdict registered on entry to DONE so it is valid alongside the done pulse
            all_pass_nxt = (fail_mask_nxt == '0);
            state_nxt    = S_DONE;
          end else begin
            state_nxt = S_START;
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      fail_mask  <= '0;
      run_count  <= '0;
      all_pass   <= 1'b0;
      dut_start  <= 1'b0;
      dut_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      fail_mask  <= fail_mask_nxt;
      run_count  <= run_count_nxt;
      all_pass   <= all_pass_nxt;
      dut_start  <= (state_nxt == S_START);
      dut_enable <= (state_nxt == S_START) || (state_nxt == S_RUN);
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_bram_dut_sequencer.sv
// Purpose: exercises two sequencer instances (bounded run count and continuous, narrow counter).
// Latency: each step drives inputs, clocks one edge, and compares outputs 1 time unit later.
// Backpressure: not applicable; all waits are fixed cycle counts.
module tb_bram_dut_sequencer;

  localparam int NUM = 4;
  localparam int RUN = 8;
  localparam int SET = 2;
  localparam int P   = 1 + RUN + SET + 1;

  logic clk = 1'b0;
  logic rst;

  logic        go_a, abort_a, start_a, en_a, busy_a, done_a, allp_a;
  logic [3:0]  pass_a, fm_a;
  logic [15:0] rc_a;

  logic        go_b, abort_b, start_b, en_b, busy_b, done_b, allp_b;
  logic [3:0]  pass_b, fm_b;
  logic [1:0]  rc_b;

  always #5 clk = ~clk;

  bram_dut_sequencer #(.NUM(NUM), .RUN_CYCLES(RUN), .SETTLE_CYCLES(SET), .NUM_RUNS(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .go(go_a), .abort(abort_a), .pass_i(pass_a),
    .dut_start(start_a), .dut_enable(en_a), .busy(busy_a), .done(done_a),
    .all_pass(allp_a), .fail_mask(fm_a), .run_count(rc_a)
  );

  bram_dut_sequencer #(.NUM(NUM), .RUN_CYCLES(RUN), .SETTLE_CYCLES(SET), .NUM_RUNS(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .abort(abort_b), .pass_i(pass_b),
    .dut_start(start_b), .dut_enable(en_b), .busy(busy_b), .done(done_b),
    .all_pass(allp_b), .fail_mask(fm_b), .run_count(rc_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a sequence is "active" with t cycles elapsed since its START.
  // Run k occupies t in [k*P, k*P+P-1]; offset P-1 is the check; t==NR*P is the done cycle.
  int         nr[2]   = '{2, 0};
  int         cmax[2] = '{65535, 3};
  bit         m_act[2];
  int         m_t[2];
  logic [3:0] m_fail[2];
  int         m_cnt[2];
  bit         m_ap[2];

  // observers for dut_a
  int cyc;
  int starts[$];
  int en_lens[$];
  int en_run;
  int dones_a, dones_b;
  int last_done_cyc;
  bit ap_done_a;
  logic [3:0]  fm_done_a;
  logic [15:0] rc_done_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_fail[i] = '0; m_cnt[i] = 0; m_ap[i] = 0;
    end
  endtask

  function automatic bit in_done(int i);
    return m_act[i] && nr[i] != 0 && m_t[i] == nr[i] * P;
  endfunction

  function automatic bit at_check(int i);
    return m_act[i] && !in_done(i) && (m_t[i] % P == P - 1);
  endfunction

  task automatic m_edge(input int i, input bit g, input bit ab, input logic [3:0] pass);
    if (!m_act[i]) begin
      if (g) begin
        m_act[i] = 1; m_t[i] = 0; m_fail[i] = '0; m_cnt[i] = 0; m_ap[i] = 0;
      end
    end else if (ab) begin
      m_act[i] = 0;
      m_ap[i]  = 0;
    end else if (in_done(i)) begin
      m_act[i] = 0;
    end else begin
      if (at_check(i)) begin
        m_fail[i] = m_fail[i] | ~pass;
        if (m_cnt[i] < cmax[i]) m_cnt[i]++;
      end
      m_t[i]++;
      if (in_done(i)) m_ap[i] = (m_fail[i] == 4'h0);
    end
  endtask

  function automatic logic [24:0] exp_vec(int i);
    bit s, e, b, d;
    s = 0; e = 0; b = 0; d = 0;
    if (m_act[i]) begin
      b = 1;
      if (in_done(i)) d = 1;
      else begin
        s = (m_t[i] % P == 0);
        e = (m_t[i] % P <= RUN);
      end
    end
    return {s, e, b, d, m_ap[i], m_fail[i], 16'(m_cnt[i])};
  endfunction

  task automatic clr_obs();
    starts.delete(); en_lens.delete();
    en_run = 0; dones_a = 0; dones_b = 0; last_done_cyc = -100;
    ap_done_a = 0; fm_done_a = '0; rc_done_a = '0;
  endtask

  task automatic step(input bit ga, input bit aa, input logic [3:0] pa,
                      input bit gb, input bit ab, input logic [3:0] pb);
    go_a = ga; abort_a = aa; pass_a = pa;
    go_b = gb; abort_b = ab; pass_b = pb;
    @(posedge clk);
    if (!rst) begin
      m_edge(0, ga, aa, pa);
      m_edge(1, gb, ab, pb);
    end
    #1;
    cyc++;
    if (start_a) starts.push_back(cyc);
    if (en_a) en_run++;
    else if (en_run != 0) begin en_lens.push_back(en_run); en_run = 0; end
    if (done_a) begin
      dones_a++; last_done_cyc = cyc;
      ap_done_a = allp_a; fm_done_a = fm_a; rc_done_a = rc_a;
    end
    if (done_b) dones_b++;
    chk("out_a", {start_a, en_a, busy_a, done_a, allp_a, fm_a, rc_a}, exp_vec(0));
    chk("out_b", {start_b, en_b, busy_b, done_b, allp_b, fm_b, 14'd0, rc_b}, exp_vec(1));
  endtask

  // pass value for dut_a: the given value at a check, random don't-care elsewhere
  function automatic logic [3:0] pa_for(logic [3:0] v);
    if (at_check(0)) return v;
    return 4'($urandom);
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 4'($urandom), 0, 0, 4'($urandom));
  endtask

  initial begin
    int gap;
    cyc = 0;
    rst = 1;
    go_a = 0; abort_a = 0; pass_a = '0;
    go_b = 0; abort_b = 0; pass_b = '0;
    m_reset();
    clr_obs();
    #1;
    chk("reset_a", {start_a, en_a, busy_a, done_a, allp_a, fm_a, rc_a}, 25'd0);
    chk("reset_b", {start_b, en_b, busy_b, done_b, allp_b, fm_b, rc_b}, 11'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    idle(3);

    // two clean runs
    clr_obs();
    step(1, 0, 4'hF, 0, 0, 4'h0);
    for (int k = 0; k < 27; k++) step(0, 0, pa_for(4'hF), 0, 0, 4'($urandom));
    chk("s1_start_cnt", starts.size(), 2);
    chk("s1_start_gap", starts[1] - starts[0], P);
    chk("s1_en_cnt", en_lens.size(), 2);
    chk("s1_en_len0", en_lens[0], RUN + 1);
    chk("s1_en_len1", en_lens[1], RUN + 1);
    chk("s1_done_cnt", dones_a, 1);
    chk("s1_allpass", ap_done_a, 1);
    chk("s1_runcount", rc_done_a, 2);
    chk("s1_failmask", fm_done_a, 0);

    // failure in the second check only
    clr_obs();
    step(1, 0, 4'h0, 0, 0, 4'h0);
    for (int k = 0; k < 27; k++) begin
      if (at_check(0)) step(0, 0, (m_t[0] / P == 1) ? 4'hB : 4'hF, 0, 0, 4'($urandom));
      else             step(0, 0, 4'($urandom), 0, 0, 4'($urandom));
    end
    chk("s2_done_cnt", dones_a, 1);
    chk("s2_failmask", fm_done_a, 4'h4);
    chk("s2_allpass", ap_done_a, 0);

    // abort in the third RUN cycle
    clr_obs();
    step(1, 0, 4'h0, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 4'h0);
    step(0, 0, 4'h0, 0, 0, 4'h0);
    step(0, 1, 4'h0, 0, 0, 4'h0);
    chk("s3_busy", busy_a, 0);
    chk("s3_enable", en_a, 0);
    chk("s3_allpass", allp_a, 0);
    idle(4);
    chk("s3_no_done", dones_a, 0);

    // go held high: back-to-back sequences, failures cleared on restart
    clr_obs();
    for (int k = 0; k < 2 * P + 4; k++) step(1, 0, pa_for(4'h7), 0, 0, 4'($urandom));
    chk("s4_done_cnt", dones_a, 1);
    chk("s4_fm_at_done", fm_done_a, 4'h8);
    gap = starts[starts.size() - 1] - last_done_cyc;
    chk("s4_restart_gap", gap, 2);
    chk("s4_fm_cleared", fm_a, 0);
    step(0, 1, 4'h0, 0, 0, 4'h0);

    // asynchronous reset in SETTLE
    clr_obs();
    step(1, 0, 4'h0, 0, 0, 4'h0);
    for (int k = 0; k < RUN + 1; k++) step(0, 0, 4'($urandom), 0, 0, 4'h0);
    chk("s5_in_settle", {busy_a, en_a}, 2'b10);
    #2;
    rst = 1;
    #1;
    chk("s5_async_a", {start_a, en_a, busy_a, done_a, allp_a, fm_a, rc_a}, 25'd0);
    chk("s5_async_b", {start_b, en_b, busy_b, done_b, allp_b, fm_b, rc_b}, 11'd0);
    m_reset();
    #1;
    rst = 0;
    idle(6);
    chk("s5_stays_idle", busy_a, 0);

    // continuous mode with a 2-bit run counter
    clr_obs();
    step(0, 0, 4'h0, 1, 0, 4'h0);
    for (int k = 0; k < 4 * P + 5; k++) step(0, 0, 4'h0, 0, 0, 4'($urandom));
    chk("s6_no_done", dones_b, 0);
    chk("s6_runcount_sat", rc_b, 3);
    chk("s6_busy", busy_b, 1);
    step(0, 0, 4'h0, 0, 1, 4'h0);
    chk("s6_abort_idle", busy_b, 0);
    idle(2);

    // random go/abort/pass on both instances
    for (int k = 0; k < 500; k++) begin
      step(($urandom % 8) == 0, ($urandom % 40) == 0, 4'($urandom),
           ($urandom % 8) == 0, ($urandom % 40) == 0, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
